// File: rtl/matrix_csr_file.sv
// rtl/matrix_csr_file.sv - parametrised matrix coprocessor CSR file
// Software CSR access over a registered valid/ready pair plus hardware flag/restart-row updates.
module matrix_csr_file #(
    parameter int          RLEN       = 512,
    parameter int          N_FLAG_SRC = 2,
    parameter logic [31:0] XMISA_VAL  = 32'h0000_0010
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      csr_req_valid_i,
    output logic                      csr_req_ready_o,
    input  logic [11:0]               csr_addr_i,
    input  logic [1:0]                csr_op_i,
    input  logic [31:0]               csr_wdata_i,
    output logic                      csr_rsp_valid_o,
    input  logic                      csr_rsp_ready_i,
    output logic [31:0]               csr_rdata_o,
    output logic                      csr_illegal_o,
    input  logic [N_FLAG_SRC-1:0]     flag_valid_i,
    input  logic [5*N_FLAG_SRC-1:0]   flag_i,
    input  logic                      rstart_we_i,
    input  logic [7:0]                rstart_i,
    input  logic                      instr_done_i,
    output logic [7:0]                xmrstart_o,
    output logic [4:0]                xmcsr_o,
    output logic [31:0]               xmsize_o
);
    localparam int          N_ROWS   = RLEN / 32;
    localparam logic [7:0]  ROWS_MAX = 8'(N_ROWS);
    localparam logic [15:0] K_MAX    = 16'(RLEN / 8);
    localparam logic [31:0] XMLENB   = 32'(N_ROWS * RLEN / 8);
    localparam logic [31:0] XRLENB   = 32'(RLEN / 8);

    localparam logic [11:0] ADDR_XMRSTART = 12'h802;
    localparam logic [11:0] ADDR_XMCSR    = 12'h803;
    localparam logic [11:0] ADDR_XMSIZE   = 12'h804;
    localparam logic [11:0] ADDR_XMLENB   = 12'hC20;
    localparam logic [11:0] ADDR_XRLENB   = 12'hC21;
    localparam logic [11:0] ADDR_XMISA    = 12'hCC4;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_SET   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    logic [7:0]  xmrstart_q;
    logic [4:0]  xmcsr_q;
    logic [31:0] xmsize_q;
    logic        rsp_valid_q;
    logic [31:0] rdata_q;
    logic        illegal_q;

    logic [31:0] old_val;
    logic [31:0] new_val;
    logic        known;
    logic        read_only;
    logic        illegal;
    logic        accept;
    logic        sw_commit;
    logic [4:0]  flags_in;
    logic [7:0]  rstart_clamped;
    logic [7:0]  sw_rstart;
    logic [31:0] sw_xmsize;

    assign csr_req_ready_o = rst_ni && (!rsp_valid_q || csr_rsp_ready_i);
    assign accept          = csr_req_valid_i && csr_req_ready_o;

    always_comb begin
        old_val   = '0;
        known     = 1'b1;
        read_only = 1'b0;
        case (csr_addr_i)
            ADDR_XMRSTART: old_val = {24'b0, xmrstart_q};
            ADDR_XMCSR:    old_val = {27'b0, xmcsr_q};
            ADDR_XMSIZE:   old_val = xmsize_q;
            ADDR_XMLENB:   begin old_val = XMLENB;    read_only = 1'b1; end
            ADDR_XRLENB:   begin old_val = XRLENB;    read_only = 1'b1; end
            ADDR_XMISA:    begin old_val = XMISA_VAL; read_only = 1'b1; end
            default:       known = 1'b0;
        endcase
        illegal = !known || (read_only && csr_op_i != OP_READ);
        case (csr_op_i)
            OP_WRITE: new_val = csr_wdata_i;
            OP_SET:   new_val = old_val | csr_wdata_i;
            OP_CLEAR: new_val = old_val & ~csr_wdata_i;
            default:  new_val = old_val;
        endcase
    end

    assign sw_commit = accept && !illegal && csr_op_i != OP_READ;

    // Row indices past the last row collapse onto the last row.
    assign rstart_clamped = (rstart_i >= ROWS_MAX) ? ROWS_MAX - 8'd1 : rstart_i;
    assign sw_rstart      = (new_val[7:0] >= ROWS_MAX) ? ROWS_MAX - 8'd1 : new_val[7:0];
    assign sw_xmsize[7:0]   = (new_val[7:0]   > ROWS_MAX) ? ROWS_MAX : new_val[7:0];
    assign sw_xmsize[15:8]  = (new_val[15:8]  > ROWS_MAX) ? ROWS_MAX : new_val[15:8];
    assign sw_xmsize[31:16] = (new_val[31:16] > K_MAX)    ? K_MAX    : new_val[31:16];

    always_comb begin
        flags_in = '0;
        for (int u = 0; u < N_FLAG_SRC; u++) begin
            if (flag_valid_i[u]) flags_in = flags_in | flag_i[5*u +: 5];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            xmrstart_q <= '0;
            xmcsr_q    <= '0;
            xmsize_q   <= {K_MAX, ROWS_MAX, ROWS_MAX};
        end else begin
            if (rstart_we_i)
                xmrstart_q <= rstart_clamped;
            else if (instr_done_i)
                xmrstart_q <= '0;
            else if (sw_commit && csr_addr_i == ADDR_XMRSTART)
                xmrstart_q <= sw_rstart;
            // Hardware flags are ORed after the software result so a clear never loses them.
            if (sw_commit && csr_addr_i == ADDR_XMCSR)
                xmcsr_q <= new_val[4:0] | flags_in;
            else
                xmcsr_q <= xmcsr_q | flags_in;
            if (sw_commit && csr_addr_i == ADDR_XMSIZE)
                xmsize_q <= sw_xmsize;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            illegal_q   <= 1'b0;
        end else if (accept) begin
            rsp_valid_q <= 1'b1;
            rdata_q     <= illegal ? 32'b0 : old_val;
            illegal_q   <= illegal;
        end else if (csr_rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
        end
    end

    assign csr_rsp_valid_o = rsp_valid_q;
    assign csr_rdata_o     = rdata_q;
    assign csr_illegal_o   = illegal_q;
    assign xmrstart_o      = xmrstart_q;
    assign xmcsr_o         = xmcsr_q;
    assign xmsize_o        = xmsize_q;
endmodule

// File: tb/tb_matrix_csr_file.sv
// tb/tb_matrix_csr_file.sv - self-checking bench for matrix_csr_file
// Directed vector table, hand sequences for same-cycle/backpressure/reset cases, then random vs model.
module tb_matrix_csr_file;
    localparam int RLEN = 512;
    localparam int NR   = RLEN / 32;
    localparam int KB   = RLEN / 8;
    localparam int NF   = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready;
    logic [11:0] addr;
    logic [1:0]  op;
    logic [31:0] wdata;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rdata;
    logic        illegal;
    logic [NF-1:0]   flag_valid;
    logic [5*NF-1:0] flag;
    logic        rstart_we;
    logic [7:0]  rstart;
    logic        instr_done;
    logic [7:0]  xmrstart;
    logic [4:0]  xmcsr;
    logic [31:0] xmsize;

    always #5 clk = ~clk;

    matrix_csr_file #(.RLEN(RLEN), .N_FLAG_SRC(NF), .XMISA_VAL(32'h0000_0010)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .csr_req_valid_i(req_valid), .csr_req_ready_o(req_ready),
        .csr_addr_i(addr), .csr_op_i(op), .csr_wdata_i(wdata),
        .csr_rsp_valid_o(rsp_valid), .csr_rsp_ready_i(rsp_ready),
        .csr_rdata_o(rdata), .csr_illegal_o(illegal),
        .flag_valid_i(flag_valid), .flag_i(flag),
        .rstart_we_i(rstart_we), .rstart_i(rstart), .instr_done_i(instr_done),
        .xmrstart_o(xmrstart), .xmcsr_o(xmcsr), .xmsize_o(xmsize)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [11:0] addr;
        logic [1:0]  op;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        ill;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input logic [11:0] a, input logic [1:0] o, input logic [31:0] w,
                       input logic [31:0] r, input logic il);
        vec_t v;
        v.addr = a; v.op = o; v.wdata = w; v.rdata = r; v.ill = il;
        vecs.push_back(v);
    endtask

    task automatic clear_inputs();
        req_valid = 0; addr = '0; op = '0; wdata = '0; rsp_ready = 1;
        flag_valid = '0; flag = '0; rstart_we = 0; rstart = '0; instr_done = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    task automatic idle();
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic do_req(input logic [11:0] a, input logic [1:0] o, input logic [31:0] w,
                          output logic [31:0] rd, output logic il);
        @(negedge clk);
        req_valid = 1; addr = a; op = o; wdata = w; rsp_ready = 1;
        @(negedge clk);
        req_valid = 0;
        chk("rsp_valid_after_accept", rsp_valid, 1);
        rd = rdata;
        il = illegal;
    endtask

    // Reference model state, updated from the architectural rules once per clock.
    logic [31:0] m_rstart, m_csr, m_size, m_rd;
    logic        m_vld, m_ill;

    function automatic logic [31:0] lim(input logic [31:0] v, input logic [31:0] m);
        return (v > m) ? m : v;
    endfunction

    task automatic model_step();
        logic [31:0] old, val, fl, n_rstart, n_csr, n_size;
        logic known, ro, ill, acc;
        acc = req_valid && (!m_vld || rsp_ready);
        known = 1; ro = 0; old = 0;
        case (addr)
            12'h802: old = m_rstart;
            12'h803: old = m_csr;
            12'h804: old = m_size;
            12'hC20: begin old = NR * KB; ro = 1; end
            12'hC21: begin old = KB; ro = 1; end
            12'hCC4: begin old = 32'h10; ro = 1; end
            default: known = 0;
        endcase
        ill = !known || (ro && op != 2'd0);
        if (op == 2'd1)      val = wdata;
        else if (op == 2'd2) val = old | wdata;
        else                 val = old & ~wdata;
        n_rstart = m_rstart; n_csr = m_csr; n_size = m_size;
        if (acc && !ill && op != 2'd0) begin
            if (addr == 12'h802) n_rstart = lim(val % 256, NR - 1);
            if (addr == 12'h803) n_csr = val % 32;
            if (addr == 12'h804)
                n_size = lim(val / 65536, KB) * 65536 + lim((val / 256) % 256, NR) * 256
                         + lim(val % 256, NR);
        end
        fl = 0;
        for (int u = 0; u < NF; u++)
            if (flag_valid[u]) fl = fl | (({22'b0, flag} >> (5 * u)) & 32'h1F);
        n_csr = n_csr | fl;
        if (rstart_we)       n_rstart = lim({24'b0, rstart}, NR - 1);
        else if (instr_done) n_rstart = 0;
        if (acc) begin
            m_vld = 1; m_rd = ill ? 0 : old; m_ill = ill;
        end else if (rsp_ready) begin
            m_vld = 0;
        end
        m_rstart = n_rstart; m_csr = n_csr; m_size = n_size;
    endtask

    logic [11:0] addr_pool [7];
    logic [31:0] got_rd;
    logic        got_il;

    initial begin
        rst_n = 0;
        clear_inputs();
        do_reset();

        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rdata", rdata, 0);
        chk("reset_illegal", illegal, 0);
        chk("reset_xmrstart", xmrstart, 0);
        chk("reset_xmcsr", xmcsr, 0);
        chk("reset_xmsize", xmsize, 32'h0040_1010);

        add(12'h804, 2'd0, 32'h0,         32'h0040_1010, 0);
        add(12'hC20, 2'd0, 32'h0,         32'h0000_0400, 0);
        add(12'hC21, 2'd0, 32'h0,         32'h0000_0040, 0);
        add(12'hCC4, 2'd0, 32'h0,         32'h0000_0010, 0);
        add(12'h804, 2'd1, 32'h0100_FF05, 32'h0040_1010, 0);
        add(12'h804, 2'd0, 32'h0,         32'h0040_1005, 0);
        add(12'hC21, 2'd1, 32'h1234,      32'h0,         1);
        add(12'h7FF, 2'd0, 32'h0,         32'h0,         1);
        add(12'h7FF, 2'd2, 32'hFFFF_FFFF, 32'h0,         1);
        add(12'hC21, 2'd0, 32'h0,         32'h0000_0040, 0);
        add(12'h802, 2'd1, 32'd200,       32'h0,         0);
        add(12'h802, 2'd0, 32'h0,         32'h0000_000F, 0);
        add(12'h802, 2'd1, 32'hFFFF_FF05, 32'h0000_000F, 0);
        add(12'h802, 2'd0, 32'h0,         32'h0000_0005, 0);
        add(12'h803, 2'd2, 32'h13,        32'h0,         0);
        add(12'h803, 2'd3, 32'h03,        32'h0000_0013, 0);
        add(12'h803, 2'd0, 32'h0,         32'h0000_0010, 0);
        add(12'hCC4, 2'd3, 32'hFFFF_FFFF, 32'h0,         1);
        add(12'h804, 2'd2, 32'h0000_0100, 32'h0040_1005, 0);
        add(12'h804, 2'd1, 32'h0,         32'h0040_1005, 0);
        add(12'h804, 2'd0, 32'h0,         32'h0,         0);
        add(12'h804, 2'd1, 32'h0040_0F10, 32'h0,         0);
        add(12'h804, 2'd0, 32'h0,         32'h0040_0F10, 0);
        add(12'h804, 2'd1, 32'h0041_0011, 32'h0040_0F10, 0);
        add(12'h804, 2'd0, 32'h0,         32'h0040_0010, 0);
        for (int i = 0; i < vecs.size(); i++) begin
            do_req(vecs[i].addr, vecs[i].op, vecs[i].wdata, got_rd, got_il);
            chk($sformatf("vec%0d_rdata", i), got_rd, vecs[i].rdata);
            chk($sformatf("vec%0d_illegal", i), got_il, vecs[i].ill);
        end
        chk("table_xmsize", xmsize, 32'h0040_0010);
        chk("table_xmrstart", xmrstart, 8'd5);

        // Backpressure: one response held for 3 cycles, the waiting request taken once on release.
        idle();
        @(negedge clk);
        req_valid = 1; addr = 12'hC21; op = 2'd0; rsp_ready = 0;
        #1 chk("bp_ready_initial", req_ready, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            addr = 12'hC20;
            #1;
            chk("bp_ready_low", req_ready, 0);
            chk("bp_rsp_valid_held", rsp_valid, 1);
            chk("bp_rdata_held", rdata, 32'h40);
        end
        @(negedge clk);
        rsp_ready = 1;
        #1 chk("bp_ready_release", req_ready, 1);
        @(negedge clk);
        req_valid = 0;
        chk("bp_second_valid", rsp_valid, 1);
        chk("bp_second_rdata", rdata, 32'h400);
        @(negedge clk);
        chk("bp_drained", rsp_valid, 0);

        // Same-cycle clear and flag: the incoming flag survives the clear.
        do_req(12'h803, 2'd2, 32'h1B, got_rd, got_il);
        chk("flag_pre_set", xmcsr, 5'h1B);
        @(negedge clk);
        req_valid = 1; addr = 12'h803; op = 2'd3; wdata = 32'h1F;
        flag_valid = 2'b10; flag = {5'h04, 5'h1F};
        @(negedge clk);
        clear_inputs();
        chk("flag_clear_rdata", rdata, 32'h1B);
        chk("flag_clear_xmcsr", xmcsr, 5'h04);

        // Hardware restart-row write beats a simultaneous software write and is clamped.
        @(negedge clk);
        req_valid = 1; addr = 12'h802; op = 2'd1; wdata = 32'd3;
        rstart_we = 1; rstart = 8'd200;
        @(negedge clk);
        clear_inputs();
        chk("rstart_prio_rdata", rdata, 32'd5);
        chk("rstart_prio_xmrstart", xmrstart, 8'd15);
        @(negedge clk);
        rstart_we = 1; rstart = 8'd7;
        @(negedge clk);
        rstart_we = 0;
        chk("rstart_7", xmrstart, 8'd7);
        instr_done = 1;
        @(negedge clk);
        instr_done = 0;
        chk("rstart_done_clear", xmrstart, 8'd0);

        // Asynchronous reset with a response pending; a request during reset is ignored.
        @(negedge clk);
        req_valid = 1; addr = 12'h803; op = 2'd0;
        @(negedge clk);
        req_valid = 1; rsp_ready = 0;
        chk("rst_pending_valid", rsp_valid, 1);
        #2 rst_n = 0;
        #1;
        chk("rst_async_valid", rsp_valid, 0);
        chk("rst_async_ready", req_ready, 0);
        chk("rst_async_xmcsr", xmcsr, 0);
        @(negedge clk);
        req_valid = 0;
        rst_n = 1;
        #1 chk("rst_no_accept", rsp_valid, 0);
        chk("rst_xmsize", xmsize, 32'h0040_1010);

        // Random traffic against the reference model from a clean reset.
        do_reset();
        m_rstart = 0; m_csr = 0; m_size = 32'h0040_1010;
        m_vld = 0; m_rd = 0; m_ill = 0;
        addr_pool[0] = 12'h802; addr_pool[1] = 12'h803; addr_pool[2] = 12'h804;
        addr_pool[3] = 12'hC20; addr_pool[4] = 12'hC21; addr_pool[5] = 12'hCC4;
        addr_pool[6] = 12'h7FF;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            chk("rnd_xmrstart", xmrstart, m_rstart);
            chk("rnd_xmcsr", xmcsr, m_csr);
            chk("rnd_xmsize", xmsize, m_size);
            chk("rnd_rsp_valid", rsp_valid, m_vld);
            if (m_vld) begin
                chk("rnd_rdata", rdata, m_rd);
                chk("rnd_illegal", illegal, m_ill);
            end
            req_valid = ($urandom % 3) != 0;
            addr = (($urandom % 8) == 7) ? 12'($urandom) : addr_pool[$urandom % 7];
            op = 2'($urandom);
            wdata = (($urandom % 2) == 0) ? $urandom : ($urandom % 64) * 32'h0001_0101;
            rsp_ready = ($urandom % 4) != 0;
            flag_valid = (($urandom % 4) == 0) ? NF'($urandom) : '0;
            flag = (5*NF)'($urandom);
            rstart_we = ($urandom % 8) == 0;
            rstart = 8'($urandom);
            instr_done = ($urandom % 8) == 0;
            #1 chk("rnd_req_ready", req_ready, !m_vld || rsp_ready);
            model_step();
        end
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/matrix_csr_file.md
Name: matrix_csr_file

Overview:
- Functional, parametrised CSR file for the matrix coprocessor. Replaces the fixed-RLEN CSR stub.
- Holds writable xmrstart, xmcsr and xmsize, plus read-only xmlenb, xrlenb and xmisa.
- Serves CSR read, write, set and clear requests from the decoder over a valid/ready request/response pair.
- Accepts hardware updates from the execution units: sticky flags and restart-row tracking.

Parameters:
- RLEN, 512, row length in bits; legal values are 128..4096, power of 2. N_ROWS = RLEN/32 is derived, not overridable.
- N_FLAG_SRC, 2, number of execution units reporting xmcsr flags.
- XMISA_VAL, 32'h0000_0010, read-only xmisa value (MULT_F32F32 only).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- csr_req_valid_i  in  1  request valid
- csr_req_ready_o  out  1  request ready
- csr_addr_i  in  12  CSR address
- csr_op_i  in  2  operation: 00 read, 01 write, 10 set, 11 clear
- csr_wdata_i  in  32  write/set/clear operand
- csr_rsp_valid_o  out  1  response valid
- csr_rsp_ready_i  in  1  response ready
- csr_rdata_o  out  32  old CSR value
- csr_illegal_o  out  1  illegal-access flag for this response
- flag_valid_i  in  N_FLAG_SRC  per-unit flag update strobe
- flag_i  in  5*N_FLAG_SRC  per-unit exception flags; unit u uses [5u+4:5u]
- rstart_we_i  in  1  hardware restart-row write (load/store unit trap)
- rstart_i  in  8  restart row index
- instr_done_i  in  1  matrix instruction retired; clears xmrstart
- xmrstart_o  out  8  current xmrstart row index
- xmcsr_o  out  5  current sticky flags
- xmsize_o  out  32  current xmsize

Behaviour:
- Address map:
  - xmrstart 0x802: bits [7:0] row index, upper bits read 0.
  - xmcsr 0x803: bits [4:0] sticky flags.
  - xmsize 0x804: [7:0] M, [15:8] N, [31:16] K in bytes.
  - xmlenb 0xC20: N_ROWS*RLEN/8.
  - xrlenb 0xC21: RLEN/8.
  - xmisa 0xCC4: XMISA_VAL.
- Handshake:
  - csr_req_ready_o = !csr_rsp_valid_o || csr_rsp_ready_i (combinational).
  - A request is accepted when valid && ready.
  - The response is registered: csr_rsp_valid_o rises the cycle after acceptance.
  - csr_rsp_valid_o, csr_rdata_o and csr_illegal_o hold stable until csr_rsp_ready_i.
  - Back-to-back accepts sustain 1 request/cycle when csr_rsp_ready_i stays high.
- csr_rdata_o always returns the value before the access. The update commits in the accept cycle, visible on outputs in the next cycle.
- New value by operation: write = wdata; set = old | wdata; clear = old & ~wdata. Only implemented bits are stored.
- xmsize write: M and N each saturate to N_ROWS; K saturates to RLEN/8. A value of 0 is stored as 0.
- Illegal conditions:
  - Unknown address with any op: illegal.
  - Op other than read to a read-only CSR: illegal.
  - On illegal: csr_illegal_o=1, csr_rdata_o=0, no state change.
  - Read of a read-only CSR is legal.
- xmcsr flags: each cycle xmcsr |= OR over u of (flag_valid_i[u] ? flag_i[u] : 0).
  - Same-cycle software access: result = software result | incoming flags. Flags are never lost, even on clear.
- xmrstart update priority, per cycle: rstart_we_i, then instr_done_i (clear to 0), then software write/set/clear.
  - rstart_i values >= N_ROWS are stored as N_ROWS-1.
  - A software write to xmrstart follows the same clamp.
- Reset, asynchronous:
  - csr_rsp_valid_o=0, csr_rdata_o=0, csr_illegal_o=0.
  - xmrstart=0, xmcsr=0.
  - xmsize = {RLEN/8, N_ROWS, N_ROWS}.
  - A pending response is dropped. No request is accepted while rst_ni is low.
- All widths are constant for every legal RLEN: N_ROWS <= 128 fits 8 bits; RLEN/8 <= 512 fits 16 bits.

Test Plan:
- Reset, then read 0x804 with RLEN=512 -> rdata 32'h0040_1010, illegal=0. Then read 0xC20 -> 32'h400; 0xC21 -> 32'h40; 0xCC4 -> 32'h10.
- Write 0x804 with 32'h0100_FF05, then read 0x804 -> first rdata 32'h0040_1010; second rdata 32'h0040_1005 (N clamped to 16, K to 64).
- Write to 0xC21, and any op on 0x7FF -> illegal=1, rdata=0, subsequent read of 0xC21 still 32'h40.
- Hold csr_rsp_ready_i=0 for 3 cycles with req_valid high -> req_ready=0, response held stable, exactly one request consumed per released response.
- Same-cycle events:
  - clear 0x803 with wdata 5'h1F while flag_valid_i=2'b10, flag_i unit1=5'h04 -> xmcsr_o=5'h04.
  - rstart_we_i=1 with rstart_i=200 plus simultaneous software write 3 to 0x802 -> xmrstart_o=15.
- rstart_we_i with rstart_i=7, then instr_done_i -> xmrstart_o 7 then 0. Assert rst_ni mid-response -> rsp_valid drops immediately.
